// File: rtl/cv32e40s_fencei_flush_responder_if.sv
// Signal bundle between the controller side and the fence.i flush responder.
// Handshakes: req is held until ack; an invalidate transfers in any cycle where inval_valid_o && inval_ready_i, and valid/idx stay stable until then.
interface cv32e40s_fencei_flush_responder_if #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 2
);
   logic             fencei_flush_req_i;
   logic             fencei_flush_ack_o;
   logic             obi_req_i;
   logic             obi_gnt_i;
   logic             obi_rvalid_i;
   logic             wbuf_empty_i;
   logic             inval_valid_o;
   logic [IDX_W-1:0] inval_idx_o;
   logic             inval_ready_i;
   logic             busy_o;
   logic             timeout_err_o;
   logic [1:0]       dbg_state;
   logic [CNT_W-1:0] dbg_count;

   modport master (
      output fencei_flush_req_i, obi_req_i, obi_gnt_i, obi_rvalid_i, wbuf_empty_i, inval_ready_i,
      input  fencei_flush_ack_o, inval_valid_o, inval_idx_o, busy_o, timeout_err_o, dbg_state, dbg_count
   );

   modport slave (
      input  fencei_flush_req_i, obi_req_i, obi_gnt_i, obi_rvalid_i, wbuf_empty_i, inval_ready_i,
      output fencei_flush_ack_o, inval_valid_o, inval_idx_o, busy_o, timeout_err_o, dbg_state, dbg_count
   );
endinterface

// File: rtl/cv32e40s_fencei_flush_responder.sv
// fence.i flush responder: drain data OBI + write buffer, sweep I-cache invalidate, one-cycle ack.
// Optional drain watchdog enabled by defining CV32E40S_FENCEI_TIMEOUT_EN.
module cv32e40s_fencei_flush_responder #(
   parameter int NUM_LINES       = 16,
   parameter int MAX_OUTSTANDING = 2,
   parameter int TIMEOUT_CYCLES  = 1024,
   localparam int IDX_W = $clog2(NUM_LINES),
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
   input logic clk,
   input logic rst,
   cv32e40s_fencei_flush_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      INVAL = 2'd2,
      ACK   = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LINES - 1);

   if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0 || TIMEOUT_CYCLES < 2 || MAX_OUTSTANDING < 1) begin : g_param_check
      $error("cv32e40s_fencei_flush_responder: illegal parameter combination");
   end

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic             ack_q, ack_d;
   logic             inc, dec, drain_ok, wd_expired;

   assign inc = bus.obi_req_i & bus.obi_gnt_i;
   assign dec = bus.obi_rvalid_i;

   // Saturating count; drain looks at the post-update value so a final rvalid ends the wait this cycle.
   always_comb begin
      count_d = count_q;
      if (inc && !dec && count_q != CNT_MAX) begin
         count_d = count_q + CNT_W'(1);
      end else if (dec && !inc && count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   assign drain_ok = (count_d == '0) && bus.wbuf_empty_i;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         count_q <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (bus.fencei_flush_req_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (drain_ok || wd_expired) begin
               state_d = INVAL;
               idx_d   = '0;
            end
         end
         INVAL: begin
            if (bus.inval_ready_i) begin
               if (idx_q == IDX_LAST) state_d = ACK;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output logic, decoded from the next state so every output leaves a flop
   always_comb begin
      busy_d  = (state_d != IDLE);
      valid_d = (state_d == INVAL);
      ack_d   = (state_d == ACK);
   end

`ifdef CV32E40S_FENCEI_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES);
   logic [WD_W-1:0] wd_q;
   logic            err_q;

   assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q <= (state_q == DRAIN && state_d == DRAIN) ? wd_q + WD_W'(1) : '0;
         if (state_q == DRAIN && !drain_ok && wd_expired) begin
            err_q <= 1'b1;
         end else if (state_q == IDLE && bus.fencei_flush_req_i) begin
            err_q <= 1'b0;
         end
      end
   end

   assign bus.timeout_err_o = err_q;
`else
   assign wd_expired        = 1'b0;
   assign bus.timeout_err_o = 1'b0;
`endif

   assign bus.fencei_flush_ack_o = ack_q;
   assign bus.inval_valid_o      = valid_q;
   assign bus.inval_idx_o        = idx_q;
   assign bus.busy_o             = busy_q;
   assign bus.dbg_state          = state_q;
   assign bus.dbg_count          = count_q;

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(inc && !dec && count_q == CNT_MAX));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(dec && !inc && count_q == '0));
   a_req_drop_after_ack: assert property (@(posedge clk) disable iff (rst) ack_q |=> !bus.fencei_flush_req_i);

endmodule

// File: tb/tb_cv32e40s_fencei_flush_responder.sv
// Bench for cv32e40s_fencei_flush_responder: directed scenarios plus randomized traffic against a flush-level model.
module tb_cv32e40s_fencei_flush_responder;
  localparam int NL    = 16;
  localparam int MAXO  = 2;
  localparam int TO    = 8;
  localparam int IDX_W = $clog2(NL);
  localparam int CNT_W = $clog2(MAXO + 1);

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cv32e40s_fencei_flush_responder_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  cv32e40s_fencei_flush_responder #(
    .NUM_LINES(NL), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // flush-level reference model
  int m_count;
  bit m_active, m_drained, m_prev_ack, m_err;
  int m_lines, m_wd;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_valid();
    return m_active && m_drained && (m_lines < NL);
  endfunction

  function automatic bit m_ack();
    return m_active && m_drained && (m_lines == NL);
  endfunction

  task automatic observe();
    @(negedge clk);
    cyc++;
    check_eq("busy", bus.busy_o, m_active);
    check_eq("inval_valid", bus.inval_valid_o, m_valid());
    check_eq("ack", bus.fencei_flush_ack_o, m_ack());
    check_eq("timeout_err", bus.timeout_err_o, m_err);
    check_eq("count", bus.dbg_count, m_count);
    if (m_valid()) check_eq("inval_idx", bus.inval_idx_o, m_lines);
  endtask

  // driver: applies one cycle of inputs and advances the model across the coming edge
  task automatic tick(input bit r, input bit oq, input bit g, input bit rv,
                      input bit wb, input bit rd, input bit rs);
    int c;
    bit ack_now;
    bus.fencei_flush_req_i = r;
    bus.obi_req_i          = oq;
    bus.obi_gnt_i          = g;
    bus.obi_rvalid_i       = rv;
    bus.wbuf_empty_i       = wb;
    bus.inval_ready_i      = rd;
    rst                    = rs;

    if (!rs && m_valid() && rd) exp_q.push_back(IDX_W'(m_lines));
    if (!rs && bus.inval_valid_o === 1'b1 && rd) begin
      check_eq("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check_eq("sb_idx", bus.inval_idx_o, exp_q.pop_front());
    end

    c = m_count + ((oq && g) ? 1 : 0) - (rv ? 1 : 0);
    if (c > MAXO) c = MAXO;
    if (c < 0) c = 0;
    ack_now = m_ack();
    if (rs) begin
      m_active = 0; m_drained = 0; m_lines = 0; m_wd = 0; m_err = 0;
      m_count = 0; m_prev_ack = 0;
      exp_q.delete();
      return;
    end
    if (!m_active) begin
      if (r) begin
        m_active = 1; m_drained = 0; m_lines = 0; m_wd = 0; m_err = 0;
      end
    end else if (!m_drained) begin
      if (c == 0 && wb) m_drained = 1;
`ifdef CV32E40S_FENCEI_TIMEOUT_EN
      else if (m_wd == TO - 1) begin
        m_drained = 1;
        m_err     = 1;
      end else m_wd++;
`endif
    end else if (m_lines < NL) begin
      if (rd) m_lines++;
    end else begin
      m_active = 0;
    end
    m_prev_ack = ack_now;
    m_count    = c;
  endtask

  task automatic idle_cycle();
    observe();
    tick(0, 0, 0, 0, 1, 1, 0);
  endtask

  // mode 0 idle, 1 rvalid at 5/9, 2 ready stall at idx 7, 3 rvalid at 3, 4 wbuf stuck busy
  task automatic do_flush(input int mode, output int lat);
    int stalls;
    bit rd, rv, wb;
    stalls = 0;
    lat    = -1;
    for (int k = 0; k < 200; k++) begin
      observe();
      if (bus.fencei_flush_ack_o === 1'b1) lat = k;
      rv = (mode == 1 && (k == 5 || k == 9)) || (mode == 3 && k == 3);
      wb = (mode != 4);
      rd = 1;
      if (mode == 2 && m_valid() && m_lines == 7 && stalls < 3) begin
        rd = 0;
        stalls++;
      end
      tick(1, 0, 0, rv, wb, rd, 0);
      if (lat >= 0) break;
    end
    idle_cycle();
  endtask

  task automatic rand_cycle();
    bit r, oq, g, rv, wb, rd, rs;
    rs = ($urandom_range(0, 299) == 0);
    if (rs)              r = 0;
    else if (m_active)   r = 1;
    else if (m_prev_ack) r = 0;
    else                 r = ($urandom_range(0, 3) == 0);
    rv = (m_count > 0) && ($urandom_range(0, 2) == 0);
    oq = 1'($urandom_range(0, 1));
    g  = 1'($urandom_range(0, 1));
    if (m_count == MAXO && !rv) g = 0;
    wb = ($urandom_range(0, 3) != 0);
    rd = ($urandom_range(0, 3) != 0);
    tick(r, oq, g, rv, wb, rd, rs);
  endtask

  int  lat;
  bit  hit;

  initial begin
    rst = 1'b1;
    bus.fencei_flush_req_i = 0; bus.obi_req_i = 0; bus.obi_gnt_i = 0;
    bus.obi_rvalid_i = 0; bus.wbuf_empty_i = 1; bus.inval_ready_i = 1;
    m_active = 0; m_drained = 0; m_lines = 0; m_wd = 0; m_err = 0; m_count = 0; m_prev_ack = 0;
    repeat (3) @(posedge clk);

    // reset state
    observe();
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_valid", bus.inval_valid_o, 0);
    check_eq("rst_ack", bus.fencei_flush_ack_o, 0);
    check_eq("rst_count", bus.dbg_count, 0);
    tick(0, 0, 0, 0, 1, 1, 0);

    // quiet bus: minimum latency
    do_flush(0, lat);
    check_eq("lat_idle", lat, NL + 2);

    // two outstanding, rvalid at cycles 5 and 9
    observe(); tick(0, 1, 1, 0, 1, 1, 0);
    observe(); tick(0, 1, 1, 0, 1, 1, 0);
    do_flush(1, lat);
    check_eq("lat_drain", lat, NL + 10);

    // three ready-low cycles at index 7
    do_flush(2, lat);
    check_eq("lat_stall", lat, NL + 5);

    // same-cycle gnt and rvalid keep count at 1
    observe(); tick(0, 1, 1, 0, 1, 1, 0);
    observe(); tick(0, 1, 1, 1, 1, 1, 0);
    observe();
    check_eq("same_cycle_cnt", bus.dbg_count, 1);
    tick(0, 0, 0, 0, 1, 1, 0);
    do_flush(3, lat);
    check_eq("lat_last_rvalid", lat, NL + 4);

    // reset in the middle of the invalidate sweep, with traffic counted during INVAL
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      observe();
      if (m_valid() && m_lines == 4) begin
        hit = 1;
        check_eq("pre_rst_idx", bus.inval_idx_o, 4);
        tick(0, 0, 0, 0, 1, 1, 1);
        break;
      end
      tick(1, 1, m_valid() && m_count < MAXO, 0, 1, 1, 0);
    end
    check_eq("rst_reached", hit, 1);
    observe();
    check_eq("mid_rst_busy", bus.busy_o, 0);
    check_eq("mid_rst_valid", bus.inval_valid_o, 0);
    check_eq("mid_rst_count", bus.dbg_count, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
    repeat (20) idle_cycle();

`ifdef CV32E40S_FENCEI_TIMEOUT_EN
    // watchdog forces the sweep when the write buffer never empties
    do_flush(4, lat);
    check_eq("lat_timeout", lat, 1 + TO + NL);
    observe();
    check_eq("to_err_sticky", bus.timeout_err_o, 1);
    tick(0, 0, 0, 0, 1, 1, 0);
    do_flush(0, lat);
    observe();
    check_eq("to_err_cleared", bus.timeout_err_o, 0);
    tick(0, 0, 0, 0, 1, 1, 0);
`endif

    // randomized traffic
    repeat (3000) begin
      observe();
      rand_cycle();
    end

    check_eq("sb_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40s_fencei_flush_responder.md
# cv32e40s_fencei_flush_responder

Responder end of the fence.i flush handshake issued by the controller FSM (`fencei_flush_req`/`fencei_flush_ack`). On a request it waits until all outstanding data-side OBI transactions and the external write buffer have drained. It then sweeps an invalidate over every line of the instruction prefetch cache and returns a single-cycle acknowledge. It sits beside the controller, monitoring the data OBI interface and driving the I-cache invalidate port.

## Interface
- NUM_LINES, 16: I-cache lines to invalidate; power of two, ≥2; IDX_W = $clog2(NUM_LINES).
- MAX_OUTSTANDING, 2: maximum data OBI transactions in flight; counter width CNT_W = $clog2(MAX_OUTSTANDING+1).
- TIMEOUT_CYCLES, 1024: drain watchdog limit (used only with the macro), ≥2.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- fencei_flush_req_i  in  1  flush request from controller; held until ack.
- fencei_flush_ack_o  out  1  one-cycle acknowledge.
- obi_req_i, obi_gnt_i, obi_rvalid_i  in  1 each  data OBI monitor signals.
- wbuf_empty_i  in  1  external write buffer empty.
- inval_valid_o  out  1  invalidate request.
- inval_idx_o  out  IDX_W  line index to invalidate.
- inval_ready_i  in  1  I-cache accepts the invalidate.
- busy_o  out  1  high in any state other than IDLE.
- timeout_err_o  out  1  drain watchdog fired (sticky).

## Operation
- Reset values: state IDLE, outstanding count 0, index 0, watchdog 0. All outputs are 0.
- Outstanding counter runs in every state:
  - Increments on obi_req_i&obi_gnt_i.
  - Decrements on obi_rvalid_i.
  - Both in the same cycle: count unchanged.
  - Holds at MAX_OUTSTANDING instead of overflowing and at 0 instead of underflowing; either case is a protocol violation and is asserted.
- FSM states: IDLE, DRAIN, INVAL, ACK.
  - IDLE: fencei_flush_req_i=1 → DRAIN.
  - DRAIN: count==0 && wbuf_empty_i → INVAL with index cleared to 0; otherwise stay.
  - INVAL:
    - inval_valid_o=1 and inval_idx_o=index.
    - inval_valid_o stays high and inval_idx_o stays stable until inval_ready_i.
    - On handshake at index==NUM_LINES-1 → ACK; otherwise index+1.
  - ACK: fencei_flush_ack_o=1 for exactly one cycle → IDLE.
- Requester rules:
  - fencei_flush_req_i must stay high from assertion through the ack cycle.
  - fencei_flush_req_i must be low in the cycle after ack; the responder asserts on violation.
  - A req seen in IDLE always starts a new flush.
- New OBI traffic during INVAL/ACK is counted but does not restart the drain.
- A request that arrives while wbuf_empty_i=0 simply waits in DRAIN.
- rst mid-operation aborts immediately: IDLE, no ack, outputs 0 on the next cycle.

## Timing
- req sampled high in cycle 0 → DRAIN in cycle 1.
- Drain satisfied in cycle 1 → INVAL in cycles 2..NUM_LINES+1, given inval_ready_i=1 throughout.
- Ack in cycle NUM_LINES+2; this is the minimum latency (18 cycles for NUM_LINES=16).
- Each inval_ready_i=0 cycle adds one cycle of latency; each DRAIN wait cycle adds one.
- All outputs come directly from registers, except inval_idx_o, which is the index register.
- busy_o is high in cycles 1..NUM_LINES+2.

## Configuration
- Macro CV32E40S_FENCEI_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in DRAIN.
  - At TIMEOUT_CYCLES-1 the FSM forces the transition to INVAL and sets timeout_err_o.
  - timeout_err_o stays set until the next request is accepted in IDLE.
  - The watchdog clears on leaving DRAIN.
- Undefined:
  - No watchdog; DRAIN waits indefinitely.
  - timeout_err_o is tied to 0.

## Test plan
- Idle bus, wbuf_empty_i=1, inval_ready_i=1, NUM_LINES=16; req at cycle 0 → inval_idx_o 0..15 in cycles 2..17; ack is a single pulse at cycle 18.
- Two granted transactions outstanding when req rises; rvalid arrives at cycles 5 and 9 → INVAL starts at cycle 10; ack at cycle 26.
- inval_ready_i low for 3 cycles while index=7 → idx holds at 7 with valid high; ack delayed by 3 cycles.
- rst asserted while in INVAL at index 4 → next cycle busy_o=0, inval_valid_o=0, count 0; no ack is issued.
- Macro defined, TIMEOUT_CYCLES=8, wbuf_empty_i stuck at 0 → INVAL entered 8 cycles after DRAIN; timeout_err_o=1 until the next req.
- Same-cycle gnt and rvalid with count=1, followed by req → count stays 1; drain completes only after the final rvalid.
